// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// byte width and the cycles-per-bit divider calculation.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Cycles per bit, rounded to the nearest integer
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO, depth 2^FIFO_DEPTH_LOG2, with an occupancy count.
// A push while full is dropped even if a pop happens on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [FIFO_DEPTH_LOG2:0] count,
    output logic                     full,
    output logic                     empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: 4-entry byte queue feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 / 8E2 framing).
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int clk_freq        = 50000000,
    parameter int baud            = 115200,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic              overflow
);

    localparam int DIV      = calc_div(clk_freq, baud);
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int BAUD_W   = $clog2(STOP_LEN + 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(DIV - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_LEN - 1);

    tx_state_t                r_state;
    tx_state_t                w_state_nxt;
    logic                     r_tx;
    logic                     w_tx_nxt;
    logic [BAUD_W-1:0]        r_baud;
    logic [BAUD_W-1:0]        w_baud_nxt;
    logic [2:0]               r_bit;
    logic [2:0]               w_bit_nxt;
    logic [DATA_W-1:0]        r_shift;
    logic                     r_ovf;
    logic                     w_pop;
    logic                     w_shift;
    logic                     w_bit_end;
    logic                     w_stop_end;
    logic [DATA_W-1:0]        w_pop_data;
    logic [FIFO_DEPTH_LOG2:0] w_count;
    logic                     w_full;
    logic                     w_empty;
`ifdef UART_TX_PARITY_EN
    logic                     r_parity;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_bit_end  = (r_baud == BIT_LAST);
    assign w_stop_end = (r_baud == STOP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_baud_nxt  = r_baud + BAUD_W'(1);
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_parity;
                        w_state_nxt = ST_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_shift   = 1'b1;
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_stop_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when a byte is waiting
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_baud_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_ovf   <= r_ovf | (wr & w_full);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shift <= w_pop_data;
        end else if (w_shift) begin
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (w_pop) r_parity <= ^w_pop_data;
    end
`endif

    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || (w_count != '0);
    assign full     = w_full;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: every cycle tx/busy/full/overflow are compared with a
// timeline model built from accepted bytes and their scheduled frame start times.
module tb_uart_tx_buf #(
    parameter int STOP_BITS = 1
);

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 4;
    localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (9 + PAR + STOP_BITS) * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    uart_tx_buf #(
        .clk_freq        (CLK_FREQ),
        .baud            (BAUD),
        .STOP_BITS       (STOP_BITS),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wr_data  (wr_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_err  = 0;
    int         cyc    = 0;
    int         t_free = 0;
    logic       m_ovf  = 1'b0;
    int         q_acc[$];
    int         q_start[$];
    logic [7:0] q_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bytes accepted by edge k whose frame has not yet started after edge k
    function automatic int m_pending(input int k);
        int n = 0;
        foreach (q_acc[i]) if (q_acc[i] <= k && q_start[i] > k) n++;
        return n;
    endfunction

    function automatic logic m_busy(input int k);
        foreach (q_acc[i]) if (q_acc[i] <= k && q_start[i] + FRAME > k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(input int k);
        int b;
        foreach (q_start[i]) begin
            if (q_start[i] <= k && k < q_start[i] + FRAME) begin
                b = (k - q_start[i]) / DIV;
                if (b == 0) return 1'b0;
                if (b <= 8) return q_data[i][b-1];
                if (PAR == 1 && b == 9) return ^q_data[i];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic int m_next_pop(input int k);
        int p = -1;
        foreach (q_start[i]) if (q_start[i] > k && (p < 0 || q_start[i] < p)) p = q_start[i];
        return p;
    endfunction

    task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
        int s;
        if (r) begin
            q_acc.delete();
            q_start.delete();
            q_data.delete();
            t_free = 0;
            m_ovf  = 1'b0;
        end else if (w) begin
            if (m_pending(cyc - 1) >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                s = (cyc + 1 > t_free) ? cyc + 1 : t_free;
                q_acc.push_back(cyc);
                q_start.push_back(s);
                q_data.push_back(d);
                t_free = s + FRAME;
            end
        end
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic r);
        wr      = w;
        wr_data = d;
        rst     = r;
        @(posedge clk);
        cyc++;
        model_edge(w, d, r);
        #1;
        chk("tx", tx, m_tx(cyc));
        chk("busy", busy, m_busy(cyc));
        chk("full", full, (m_pending(cyc) == DEPTH));
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1'b0, 8'($urandom), 1'b0);
            k++;
        end
        chk("drain", busy, 1'b0);
    endtask

    initial begin
        int p;

        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        idle(3);

        // Single byte
        tick(1'b1, 8'h55, 1'b0);
        wait_idle(6000);
        idle(5);

        // Queue fills behind an active frame, next write overflows
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'hA5, 1'b0);
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'h0F, 1'b0);
        tick(1'b1, 8'hF0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0);
        wait_idle(30000);
        idle(5);

        // Reset mid-frame with bytes still queued
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b1, 8'hC3, 1'b0);
        idle(1997);
        tick(1'b0, 8'h00, 1'b1);
        idle(1000);

        // Push coinciding with a pop at count=2, then fill to full
        tick(1'b1, 8'h96, 1'b0);
        tick(1'b1, 8'h69, 1'b0);
        tick(1'b1, 8'hE1, 1'b0);
        p = m_next_pop(cyc);
        while (p > 0 && cyc < p - 1) tick(1'b0, 8'($urandom), 1'b0);
        tick(1'b1, 8'h1E, 1'b0);
        idle(10);
        tick(1'b1, 8'h77, 1'b0);
        tick(1'b1, 8'h88, 1'b0);
        tick(1'b1, 8'h99, 1'b0);
        idle(20);
        tick(1'b0, 8'h00, 1'b1);
        idle(5);

        // Randomly spaced random bytes
        repeat (4) begin
            idle($urandom_range(0, 2500));
            tick(1'b1, 8'($urandom), 1'b0);
        end
        wait_idle(30000);

        // Random back-to-back burst, stopped by reset
        repeat ($urandom_range(3, 7)) tick(1'b1, 8'($urandom), 1'b0);
        idle($urandom_range(1000, 4000));
        tick(1'b0, 8'h00, 1'b1);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
